// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and core-side valid/ready signals of the fetch front end.
// The fetch unit connects through master; the memory/core environment through slave.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a credit-limited prefetch FIFO and redirect flush.
// In-flight responses from before a redirect are counted down in discard and dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam int              PW      = $clog2(DEPTH);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];

    logic            req;
    logic            gnt_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic [CW:0]     credit_used;
    logic [31:0]     redir_tgt;

    assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
    assign redir_tgt   = bus.redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push       = 1'b0;
        pop        = 1'b0;

        // A response with nothing outstanding is spurious and ignored.
        rsp_fire = bus.imem_rvalid && (outst_q != '0);
        req      = (state_q == FETCH) && !bus.redirect_valid && (credit_used < DEPTH_C) && !rst;
        gnt_fire = req && bus.imem_gnt;

        if (bus.redirect_valid) begin
            fetch_pc_d = redir_tgt;
            resp_pc_d  = redir_tgt;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight belongs to the old stream.
            discard_d  = outst_q - CW'(rsp_fire);
            outst_d    = outst_q - CW'(rsp_fire);
            state_d    = (discard_d != '0) ? DRAIN : FETCH;
        end else begin
            pop = (count_q != '0) && bus.out_ready;
            if (gnt_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_fire) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            outst_d = outst_q + CW'(gnt_fire) - CW'(rsp_fire);
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if ((state_q == DRAIN) && (discard_q == '0)) begin
                state_d = FETCH;
            end
        end
    end

    // FIFO storage: data only, occupancy lives in count_q
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus.imem_rdata;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = (count_q != '0) ? instr_mem[rd_ptr_q] : NOP_INSTR;
    assign bus.out_pc    = (count_q != '0) ? pc_mem[rd_ptr_q] : 32'h0;
endmodule
